// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART: frame width, FSM state encodings and
// the baud-divider computation used by both directions.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_HIGH = 3'd4
  } rx_state_t;

  // Clock cycles per serial bit, rounded to nearest.
  function automatic int calc_bit_cycles(input int clk_khz, input int baud);
    return (clk_khz * 1000 + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// UART receiver: two-flop synchroniser on the serial line, then a centre-sampling
// 8N1 FSM that reports each good byte with a one-cycle ready pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BIT_CYCLES = 868,
  parameter int HALF_BIT   = 434
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_rx,
  output logic                 o_data_rdy,
  output logic [DATA_BITS-1:0] o_data
);

  localparam int CNT_W = $clog2(BIT_CYCLES + 1);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  logic                 r_rx_meta, r_rx_sync;
  rx_state_t            r_state, w_state_next;
  logic [CNT_W-1:0]     r_cnt, w_cnt_next;
  logic [IDX_W-1:0]     r_idx, w_idx_next;
  logic [DATA_BITS-1:0] r_shift, w_shift_next;
  logic [DATA_BITS-1:0] r_data, w_data_next;
  logic                 r_rdy, w_rdy_next;

  // Synchroniser idles high so reset never looks like a start bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  // Receiver state and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= RX_IDLE;
      r_cnt   <= {CNT_W{1'b0}};
      r_idx   <= {IDX_W{1'b0}};
      r_shift <= {DATA_BITS{1'b0}};
      r_data  <= {DATA_BITS{1'b0}};
      r_rdy   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
      r_shift <= w_shift_next;
      r_data  <= w_data_next;
      r_rdy   <= w_rdy_next;
    end
  end

  // Next-state logic; the start bit is re-checked at its centre to reject glitches.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_idx_next   = r_idx;
    w_shift_next = r_shift;
    w_data_next  = r_data;
    w_rdy_next   = 1'b0;
    case (r_state)
      RX_IDLE: begin
        if (!r_rx_sync) begin
          w_state_next = RX_START;
          w_cnt_next   = {CNT_W{1'b0}};
        end else begin
          w_state_next = RX_IDLE;
        end
      end
      RX_START: begin
        if (r_cnt == HALF_LAST) begin
          w_cnt_next   = {CNT_W{1'b0}};
          w_idx_next   = {IDX_W{1'b0}};
          w_state_next = r_rx_sync ? RX_IDLE : RX_DATA;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_next   = {CNT_W{1'b0}};
          w_shift_next = {r_rx_sync, r_shift[DATA_BITS-1:1]};
          if (r_idx == IDX_LAST) begin
            w_state_next = RX_STOP;
          end else begin
            w_idx_next = r_idx + IDX_W'(1);
          end
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_next = {CNT_W{1'b0}};
          if (r_rx_sync) begin
            w_data_next  = r_shift;
            w_rdy_next   = 1'b1;
            w_state_next = RX_IDLE;
          end else begin
            w_state_next = RX_WAIT_HIGH;
          end
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      RX_WAIT_HIGH: begin
        if (r_rx_sync) begin
          w_state_next = RX_IDLE;
        end else begin
          w_state_next = RX_WAIT_HIGH;
        end
      end
      default: begin
        w_state_next = RX_IDLE;
        w_cnt_next   = {CNT_W{1'b0}};
      end
    endcase
  end

  assign o_data_rdy = r_rdy;
  assign o_data     = r_data;

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART: transmit FSM with its baud counter here, receiver in uart_rx.
// Tx and tx_busy are registered and move together on frame start and end.
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int INPUT_CLK_KHZ = 100_000,
  parameter int BAUD_RATE     = 115200
) (
  input  logic       input_clk,
  input  logic       reset_n,
  input  logic       trans_en,
  input  logic [7:0] data_out,
  output logic       Tx,
  output logic       tx_busy,
  input  logic       Rx,
  output logic       data_rdy,
  output logic [7:0] data_received
);

  localparam int BIT_CYCLES = calc_bit_cycles(INPUT_CLK_KHZ, BAUD_RATE);
  localparam int HALF_BIT   = BIT_CYCLES / 2;
  localparam int CNT_W      = $clog2(BIT_CYCLES + 1);
  localparam int IDX_W      = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  tx_state_t            r_tx_state, w_tx_state_next;
  logic [CNT_W-1:0]     r_tx_cnt, w_tx_cnt_next;
  logic [IDX_W-1:0]     r_tx_idx, w_tx_idx_next;
  logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift_next;
  logic                 r_tx, w_tx_next;
  logic                 r_tx_busy, w_tx_busy_next;
  logic                 w_tx_bit_done;

  assign w_tx_bit_done = (r_tx_cnt == BIT_LAST);

  // Transmitter state and registered line outputs.
  always_ff @(posedge input_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= {CNT_W{1'b0}};
      r_tx_idx   <= {IDX_W{1'b0}};
      r_tx_shift <= {DATA_BITS{1'b0}};
      r_tx       <= 1'b1;
      r_tx_busy  <= 1'b0;
    end else begin
      r_tx_state <= w_tx_state_next;
      r_tx_cnt   <= w_tx_cnt_next;
      r_tx_idx   <= w_tx_idx_next;
      r_tx_shift <= w_tx_shift_next;
      r_tx       <= w_tx_next;
      r_tx_busy  <= w_tx_busy_next;
    end
  end

  // Next-state logic; the line value is computed for the bit about to start.
  always_comb begin
    w_tx_state_next = r_tx_state;
    w_tx_cnt_next   = r_tx_cnt;
    w_tx_idx_next   = r_tx_idx;
    w_tx_shift_next = r_tx_shift;
    w_tx_next       = r_tx;
    w_tx_busy_next  = r_tx_busy;
    case (r_tx_state)
      TX_IDLE: begin
        w_tx_next      = 1'b1;
        w_tx_busy_next = 1'b0;
        if (trans_en) begin
          w_tx_shift_next = data_out;
          w_tx_cnt_next   = {CNT_W{1'b0}};
          w_tx_state_next = TX_START;
          w_tx_next       = 1'b0;
          w_tx_busy_next  = 1'b1;
        end else begin
          w_tx_state_next = TX_IDLE;
        end
      end
      TX_START: begin
        if (w_tx_bit_done) begin
          w_tx_cnt_next   = {CNT_W{1'b0}};
          w_tx_idx_next   = {IDX_W{1'b0}};
          w_tx_state_next = TX_DATA;
          w_tx_next       = r_tx_shift[0];
        end else begin
          w_tx_cnt_next = r_tx_cnt + CNT_W'(1);
        end
      end
      TX_DATA: begin
        if (w_tx_bit_done) begin
          w_tx_cnt_next = {CNT_W{1'b0}};
          if (r_tx_idx == IDX_LAST) begin
            w_tx_state_next = TX_STOP;
            w_tx_next       = 1'b1;
          end else begin
            w_tx_idx_next   = r_tx_idx + IDX_W'(1);
            w_tx_shift_next = {1'b0, r_tx_shift[DATA_BITS-1:1]};
            w_tx_next       = r_tx_shift[1];
          end
        end else begin
          w_tx_cnt_next = r_tx_cnt + CNT_W'(1);
        end
      end
      TX_STOP: begin
        if (w_tx_bit_done) begin
          w_tx_cnt_next   = {CNT_W{1'b0}};
          w_tx_state_next = TX_IDLE;
          w_tx_next       = 1'b1;
          w_tx_busy_next  = 1'b0;
        end else begin
          w_tx_cnt_next = r_tx_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_tx_state_next = TX_IDLE;
        w_tx_next       = 1'b1;
        w_tx_busy_next  = 1'b0;
      end
    endcase
  end

  assign Tx      = r_tx;
  assign tx_busy = r_tx_busy;

  uart_rx #(
    .BIT_CYCLES(BIT_CYCLES),
    .HALF_BIT  (HALF_BIT)
  ) u_rx (
    .i_clk     (input_clk),
    .i_rst_n   (reset_n),
    .i_rx      (Rx),
    .o_data_rdy(data_rdy),
    .o_data    (data_received)
  );

endmodule

// File: tb/tb_uart_transceiver.sv
// Self-checking bench for uart_transceiver at 10 clocks per bit: table-driven
// transmit frames, a receive scoreboard, and hand sequences for the corner cases.
`timescale 1ns/1ps
module tb_uart_transceiver;

  localparam int CLK_KHZ = 1000;
  localparam int BAUD    = 100000;
  localparam int BITC    = 10;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       trans_en;
  logic [7:0] data_out;
  logic       tx;
  logic       tx_busy;
  logic       rx_drv;
  logic       loop_sel;
  logic       rx_line;
  logic       data_rdy;
  logic [7:0] data_received;

  assign rx_line = loop_sel ? tx : rx_drv;

  always #5 clk = ~clk;

  uart_transceiver #(
    .INPUT_CLK_KHZ(CLK_KHZ),
    .BAUD_RATE    (BAUD)
  ) u_dut (
    .input_clk    (clk),
    .reset_n      (reset_n),
    .trans_en     (trans_en),
    .data_out     (data_out),
    .Tx           (tx),
    .tx_busy      (tx_busy),
    .Rx           (rx_line),
    .data_rdy     (data_rdy),
    .data_received(data_received)
  );

  int         tests     = 0;
  int         fails     = 0;
  int         rdy_count = 0;
  logic [7:0] exp_q[$];
  logic       prev_rdy  = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;   // bit k = k-th bit on the line (start first)
    logic       loop;
  } tx_vec_t;

  tx_vec_t vecs[5];

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Receive scoreboard: every data_rdy pulse pops one expected byte.
  initial begin
    logic [7:0] exp_b;
    forever begin
      @(negedge clk);
      if (data_rdy === 1'b1) begin
        rdy_count++;
        chk1("rdy_single_cycle", prev_rdy, 1'b0);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rdy_unexpected: got byte %02h, expected no pulse", data_received);
        end else begin
          exp_b = exp_q.pop_front();
          chk8("rx_byte", data_received, exp_b);
        end
      end
      prev_rdy = data_rdy;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One-cycle strobe, then check every cycle of the 10-bit frame; inj >= 0
  // fires a second strobe (byte 3C) at that cycle of the frame.
  task automatic tx_frame(input logic [7:0] b, input logic [9:0] frame, input int inj);
    logic bit_ok;
    logic busy_ok;
    trans_en = 1'b1;
    data_out = b;
    @(posedge clk); #1;
    trans_en = 1'b0;
    data_out = 8'h00;
    busy_ok  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bit_ok = 1'b1;
      for (int c = 0; c < BITC; c++) begin
        if (tx !== frame[k]) bit_ok = 1'b0;
        if (tx_busy !== 1'b1) busy_ok = 1'b0;
        if (k * BITC + c == inj) begin
          trans_en = 1'b1;
          data_out = 8'h3C;
        end else begin
          trans_en = 1'b0;
        end
        @(posedge clk); #1;
      end
      chk1($sformatf("tx_%02h_bit%0d", b, k), bit_ok, 1'b1);
    end
    trans_en = 1'b0;
    chk1("tx_busy_during_frame", busy_ok, 1'b1);
    chk1("tx_busy_after_frame", tx_busy, 1'b0);
    chk1("tx_line_after_frame", tx, 1'b1);
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rx_drv = bits[k];
      repeat (BITC) @(posedge clk);
      #1;
    end
    rx_drv = 1'b1;
    repeat (20) @(posedge clk);
    #1;
  endtask

  initial begin
    int   cnt0;
    logic idle_ok;

    vecs[0] = '{8'hA5, 10'b1101001010, 1'b0};
    vecs[1] = '{8'h00, 10'b1000000000, 1'b1};
    vecs[2] = '{8'hFF, 10'b1111111110, 1'b1};
    vecs[3] = '{8'h55, 10'b1010101010, 1'b1};
    vecs[4] = '{8'h81, 10'b1100000010, 1'b1};

    reset_n  = 1'b0;
    trans_en = 1'b0;
    data_out = 8'h00;
    rx_drv   = 1'b1;
    loop_sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk1("reset_tx", tx, 1'b1);
    chk1("reset_busy", tx_busy, 1'b0);
    chk1("reset_rdy", data_rdy, 1'b0);
    chk8("reset_data", data_received, 8'h00);

    reset_n = 1'b1;
    idle_ok = 1'b1;
    repeat (200) begin
      @(posedge clk); #1;
      if (tx !== 1'b1 || tx_busy !== 1'b0 || data_rdy !== 1'b0) idle_ok = 1'b0;
    end
    chk1("idle_after_reset", idle_ok, 1'b1);

    // Table: A5 standalone, then four back-to-back loopback frames.
    cnt0 = rdy_count;
    for (int i = 0; i < 5; i++) begin
      loop_sel = vecs[i].loop;
      if (vecs[i].loop) exp_q.push_back(vecs[i].data);
      tx_frame(vecs[i].data, vecs[i].frame, -1);
    end
    repeat (5) @(posedge clk);
    #1;
    loop_sel = 1'b0;
    chk_int("loopback_pulses", rdy_count, cnt0 + 4);
    chk8("loopback_last", data_received, 8'h81);

    // Strobe mid-frame is dropped, not queued.
    tx_frame(8'hA5, 10'b1101001010, 30);
    @(posedge clk); #1;
    chk1("busy_strobe_not_queued", tx_busy, 1'b0);
    tx_frame(8'h3C, 10'b1001111000, -1);

    cnt0 = rdy_count;
    exp_q.push_back(8'h5A);
    rx_frame(8'h5A, 1'b1);
    chk8("rx_5a_data", data_received, 8'h5A);
    chk_int("rx_5a_pulses", rdy_count, cnt0 + 1);

    cnt0 = rdy_count;
    rx_drv = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx_drv = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk_int("rx_glitch_pulses", rdy_count, cnt0);

    rx_frame(8'hFF, 1'b0);
    chk_int("rx_framing_pulses", rdy_count, cnt0);
    chk8("rx_framing_data_held", data_received, 8'h5A);

    exp_q.push_back(8'h01);
    rx_frame(8'h01, 1'b1);
    chk8("rx_01_data", data_received, 8'h01);
    chk_int("rx_01_pulses", rdy_count, cnt0 + 1);

    // Reset during a loopback frame while the line is low.
    loop_sel = 1'b1;
    cnt0 = rdy_count;
    trans_en = 1'b1;
    data_out = 8'h81;
    @(posedge clk); #1;
    trans_en = 1'b0;
    repeat (35) @(posedge clk);
    #1;
    chk1("midframe_line_low", tx, 1'b0);
    reset_n = 1'b0;
    #1;
    chk1("midframe_reset_tx", tx, 1'b1);
    chk1("midframe_reset_busy", tx_busy, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    chk_int("midframe_no_rdy", rdy_count, cnt0);
    chk1("midframe_idle_tx", tx, 1'b1);
    chk8("midframe_data_cleared", data_received, 8'h00);
    loop_sel = 1'b0;

    chk_int("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_transceiver.md
Name: uart_transceiver

Overview:
Full-duplex 8N1 UART with independent transmitter and receiver sharing one clock. The transmit side accepts a byte from the controller/FIFO mux with a one-cycle strobe. The receive side delivers each good byte to the command decoder with a one-cycle ready pulse. Sits between the board serial pins and the logic-analyzer core.

Parameters:
- INPUT_CLK_KHZ, 100_000: input_clk frequency in kHz.
- BAUD_RATE, 115200: serial bit rate in bit/s.

Ports:
- input_clk  in  1  system clock.
- reset_n  in  1  reset.
- trans_en  in  1  transmit strobe; loads data_out when idle.
- data_out  in  8  byte to transmit.
- Tx  out  1  serial output, idle high.
- tx_busy  out  1  high while a frame is in flight.
- Rx  in  1  serial input, asynchronous to input_clk.
- data_rdy  out  1  one-cycle pulse, new byte valid.
- data_received  out  8  last good received byte.

Interface rule: one clock (input_clk); reset is asynchronous and active-low (reset_n). All state is on the rising edge of input_clk.

Behaviour:
- BIT_CYCLES = (INPUT_CLK_KHZ*1000 + BAUD_RATE/2) / BAUD_RATE, integer. Default is 868.
- HALF_BIT = BIT_CYCLES/2. Default is 434.
- Frame format: start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity.
- Reset values: Tx=1, tx_busy=0, data_rdy=0, data_received=8'h00. Both FSMs go to IDLE; the Rx synchroniser flops go to 1.
- TX FSM states: IDLE, START, DATA, STOP.
- IDLE: Tx=1. If trans_en=1, latch data_out into a shift register and go to START. tx_busy=1 from the next cycle.
- START, DATA, STOP: each bit is held for exactly BIT_CYCLES cycles.
- DATA: shifts the 8 bits LSB first.
- After STOP completes: return to IDLE; tx_busy=0 in the same cycle Tx finishes the stop bit.
- Frame length is 10*BIT_CYCLES cycles from the first START cycle.
- trans_en while tx_busy=1 is ignored; the byte is not queued. Back-to-back: trans_en asserted the cycle tx_busy falls starts the next frame immediately.
- data_out only needs to be valid in the trans_en cycle.
- Rx path: 2-flop synchroniser before any use.
- RX FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: a synchronised 0 goes to START.
- START: wait HALF_BIT cycles, then re-sample. If the line is 1, treat it as a glitch and return to IDLE. Otherwise go to DATA.
- DATA: sample 8 bits at bit centres, BIT_CYCLES apart, into a shift register, LSB first.
- STOP: sample at the centre.
  - If 1: load data_received, pulse data_rdy high for exactly one cycle, go to IDLE.
  - If 0 (framing error): data_received unchanged, no data_rdy, go to WAIT_HIGH.
- WAIT_HIGH: stay until the line is 1, then go to IDLE.
- data_received holds its value until the next good byte.
- Data path latency: data_rdy rises at most 2 cycles (synchroniser) after the stop-bit centre.
- TX and RX are fully independent; a loopback (Tx tied to Rx) must work.
- Asserting reset mid-frame aborts both frames immediately: Tx goes high, no partial data_rdy.

Decomposition:
- Package uart_pkg holds:
  - BIT_CYCLES / HALF_BIT computation function.
  - DATA_BITS=8.
  - The typedef enums tx_state_t and rx_state_t.
- Natural split: sub-module uart_rx (synchroniser + RX FSM).
- The TX FSM and baud counter live in the top.

Test Plan:
- Override INPUT_CLK_KHZ=1000, BAUD_RATE=100000 so BIT_CYCLES=10. Then:
- Reset: hold reset_n=0 → Tx=1, tx_busy=0, data_rdy=0, data_received=00. Release with Rx=1 → no activity for 200 cycles.
- TX byte 8'hA5 with a one-cycle trans_en → Tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 10 cycles. tx_busy high for 100 cycles, then low.
- trans_en with 8'h3C at cycle 30 of a frame → ignored, first frame unchanged. Re-issue when tx_busy=0 → 3C sent.
- Drive Rx with a 10-cycle-per-bit frame of 8'h5A → one data_rdy pulse, data_received=5A.
- Rx low for 3 cycles only (glitch) → no data_rdy, FSM back to IDLE. Frame 8'hFF with stop bit 0 → no data_rdy, data_received stays 5A. Then valid 8'h01 → data_rdy, 01.
- Loopback Tx→Rx sending 00, FF, 55, 81 back-to-back → four data_rdy pulses with matching bytes. reset_n pulsed mid-frame → Tx=1 at once, no data_rdy.
